// File: rtl/uram_update_write_arbiter.sv
// rtl/uram_update_write_arbiter.sv - per-slot round-robin write arbiter with cross-slot index conflict filter
//
// Purpose: picks one requester (hash lane) per write slot each cycle, drops
// candidates whose index collides with a surviving lower-numbered slot, and
// registers the winning lane select / index / xor data for the row writer.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pause               no grants this cycle, pointers and counter frozen
//   req_valid/req_ready per-requester handshake, bit slot*NUM_MUL+lane
//   req_index           per-requester table index
//   req_xor             per-requester xor update data
//   arbiter_result      registered one-hot granted lane per slot
//   write_reg_11_valid  registered per-slot write valid
//   write_reg_11_index  registered granted index per slot (0 when idle)
//   write_reg_11_xor    registered copy of req_xor
//   conflict_cnt        saturating count of suppressed candidates
module uram_update_write_arbiter #(
    parameter int NUM_MUL     = 4,
    parameter int NUM_WR      = 8,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pause,
    input  logic [NUM_WR*NUM_MUL-1:0]            req_valid,
    output logic [NUM_WR*NUM_MUL-1:0]            req_ready,
    input  logic [NUM_WR*NUM_MUL*INDEX_WIDTH-1:0] req_index,
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  req_xor,
    output logic [NUM_WR*NUM_MUL-1:0]            arbiter_result,
    output logic [NUM_WR-1:0]                    write_reg_11_valid,
    output logic [NUM_WR*INDEX_WIDTH-1:0]        write_reg_11_index,
    output logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  write_reg_11_xor,
    output logic [15:0]                          conflict_cnt
);

    localparam int PW = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;

    logic [PW-1:0]          ptr_q     [NUM_WR];
    logic [PW-1:0]          ptr_d     [NUM_WR];
    logic [PW-1:0]          cand_lane [NUM_WR];
    logic [INDEX_WIDTH-1:0] cand_idx  [NUM_WR];
    logic [NUM_WR-1:0]      cand_v;
    logic [NUM_WR-1:0]      surv;
    logic [NUM_WR-1:0]      grant;
    logic [NUM_WR-1:0]      suppressed;
    logic [15:0]            supp_n;
    logic [16:0]            cnt_sum;

    logic [NUM_WR*NUM_MUL-1:0]            arb_q, arb_d;
    logic [NUM_WR-1:0]                    valid_q, valid_d;
    logic [NUM_WR*INDEX_WIDTH-1:0]        index_q, index_d;
    logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  xor_q;
    logic [15:0]                          cnt_q, cnt_d;

    // Round-robin candidate: first valid lane starting at the slot pointer.
    always_comb begin
        int  lane_int;
        logic found;
        lane_int = 0;
        found    = 1'b0;
        cand_v   = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            found        = 1'b0;
            cand_lane[i] = '0;
            for (int k = 0; k < NUM_MUL; k++) begin
                lane_int = (int'(ptr_q[i]) + k) % NUM_MUL;
                if (!found && req_valid[i*NUM_MUL + lane_int]) begin
                    found        = 1'b1;
                    cand_lane[i] = PW'(lane_int);
                end
            end
            cand_v[i]   = found;
            cand_idx[i] = req_index[(i*NUM_MUL + int'(cand_lane[i]))*INDEX_WIDTH +: INDEX_WIDTH];
        end
    end

    // Conflict filter walks slots in ascending order and only compares
    // against candidates that already survived, so the lowest slot wins
    // and a suppressed slot never blocks a higher one.
    always_comb begin
        logic [NUM_WR-1:0] won;
        logic              hit;
        won = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (j < i && won[j] && cand_idx[j] == cand_idx[i]) begin
                    hit = 1'b1;
                end
            end
            won[i] = cand_v[i] && !hit;
        end
        surv = won;
    end

    assign suppressed = cand_v & ~surv;
    assign grant      = (reset || pause) ? '0 : surv;

    always_comb begin
        req_ready = '0;
        index_d   = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (grant[i]) begin
                req_ready[i*NUM_MUL + int'(cand_lane[i])] = 1'b1;
                index_d[i*INDEX_WIDTH +: INDEX_WIDTH]    = cand_idx[i];
            end
        end
    end

    assign arb_d   = req_ready;
    assign valid_d = grant;

    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            ptr_d[i] = ptr_q[i];
            if (grant[i]) begin
                ptr_d[i] = (int'(cand_lane[i]) == NUM_MUL - 1) ? '0 : cand_lane[i] + PW'(1);
            end
        end
    end

    always_comb begin
        supp_n = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            supp_n = supp_n + {15'b0, suppressed[i]};
        end
        cnt_sum = {1'b0, cnt_q} + {1'b0, supp_n};
        if (pause) begin
            cnt_d = cnt_q;
        end else if (cnt_sum[16]) begin
            cnt_d = 16'hFFFF;
        end else begin
            cnt_d = cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WR; i++) begin
                ptr_q[i] <= '0;
            end
            arb_q   <= '0;
            valid_q <= '0;
            index_q <= '0;
            xor_q   <= '0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
            arb_q   <= arb_d;
            valid_q <= valid_d;
            index_q <= index_d;
            xor_q   <= req_xor;
            cnt_q   <= cnt_d;
        end
    end

    assign arbiter_result     = arb_q;
    assign write_reg_11_valid = valid_q;
    assign write_reg_11_index = index_q;
    assign write_reg_11_xor   = xor_q;
    assign conflict_cnt       = cnt_q;

endmodule

// File: tb/tb_uram_update_write_arbiter.sv
// tb/tb_uram_update_write_arbiter.sv - self-checking bench for uram_update_write_arbiter
module tb_uram_update_write_arbiter;

    localparam int NM = 4;
    localparam int NW = 8;
    localparam int IW = 12;
    localparam int DW = 64;
    localparam int NR = NM * NW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pause = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*IW-1:0]  req_index = '0;
    logic [NR*DW-1:0]  req_xor = '0;
    logic [NR-1:0]     arbiter_result;
    logic [NW-1:0]     write_reg_11_valid;
    logic [NW*IW-1:0]  write_reg_11_index;
    logic [NR*DW-1:0]  write_reg_11_xor;
    logic [15:0]       conflict_cnt;

    uram_update_write_arbiter #(
        .NUM_MUL(NM), .NUM_WR(NW), .INDEX_WIDTH(IW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_xor(req_xor),
        .arbiter_result(arbiter_result),
        .write_reg_11_valid(write_reg_11_valid),
        .write_reg_11_index(write_reg_11_index),
        .write_reg_11_xor(write_reg_11_xor),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0]    arb;
        logic [NW-1:0]    valid;
        logic [NW*IW-1:0] idx;
        logic [15:0]      cnt;
    } exp_t;

    exp_t          sb[$];
    logic [NR-1:0] rdy_q[$];
    int            m_ptr [NW];
    int            m_cnt;
    int            vec_cnt = 0;
    int            err_cnt = 0;
    exp_t          mon_e;
    exp_t          mon_got;
    logic [NR-1:0] mon_r;

    // Reference model of one clock edge, computed from the current inputs.
    task automatic model_cycle(output logic [NR-1:0] rdy, output exp_t e);
        int   lane;
        int   supp;
        logic found;
        logic hit;
        logic [NW-1:0] won;
        logic [IW-1:0] widx [NW];
        int   glane [NW];
        rdy = '0;
        e   = '0;
        won = '0;
        supp = 0;
        if (reset) begin
            for (int i = 0; i < NW; i++) m_ptr[i] = 0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                found = 1'b0;
                lane = 0;
                widx[i] = '0;
                glane[i] = 0;
                for (int k = 0; k < NM; k++) begin
                    if (!found && req_valid[i*NM + (m_ptr[i]+k)%NM]) begin
                        found = 1'b1;
                        lane = (m_ptr[i]+k)%NM;
                    end
                end
                if (found) begin
                    hit = 1'b0;
                    for (int j = 0; j < i; j++)
                        if (won[j] && widx[j] == req_index[(i*NM+lane)*IW +: IW]) hit = 1'b1;
                    if (hit) supp++;
                    else begin
                        won[i] = 1'b1;
                        widx[i] = req_index[(i*NM+lane)*IW +: IW];
                        glane[i] = lane;
                    end
                end
            end
            if (!pause) begin
                for (int i = 0; i < NW; i++) begin
                    if (won[i]) begin
                        rdy[i*NM+glane[i]] = 1'b1;
                        e.arb[i*NM+glane[i]] = 1'b1;
                        e.valid[i] = 1'b1;
                        e.idx[i*IW +: IW] = widx[i];
                        m_ptr[i] = (glane[i]+1) % NM;
                    end
                end
                m_cnt = (m_cnt + supp > 65535) ? 65535 : m_cnt + supp;
            end
        end
        e.cnt = 16'(m_cnt);
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic drive_cycle(output logic [NR-1:0] rdy);
        exp_t e;
        #2;
        model_cycle(rdy, e);
        rdy_q.push_back(rdy);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rdy_q.size() > 0) begin
            mon_r = rdy_q.pop_front();
            vec_cnt++;
            if (req_ready !== mon_r) begin
                err_cnt++;
                $display("FAIL sb_req_ready got %h want %h at %0t", req_ready, mon_r, $time);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_got = {arbiter_result, write_reg_11_valid, write_reg_11_index, conflict_cnt};
            vec_cnt++;
            if (mon_got !== mon_e) begin
                err_cnt++;
                $display("FAIL sb_outputs got %h want %h at %0t", mon_got, mon_e, $time);
            end
        end
    end

    task automatic set_req(input int s, input int l, input logic [IW-1:0] idx, input logic [DW-1:0] x);
        req_valid[s*NM+l] = 1'b1;
        req_index[(s*NM+l)*IW +: IW] = idx;
        req_xor[(s*NM+l)*DW +: DW] = x;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_index = '0;
        req_xor = '0;
    endtask

    task automatic do_reset();
        logic [NR-1:0] r;
        reset = 1'b1;
        drive_cycle(r);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [NR-1:0] r;
        clear_req();
        set_req(4, 1, 12'h123, 64'hAA);
        reset = 1'b1;
        drive_cycle(r);
        vec_cnt++;
        if ({arbiter_result, write_reg_11_valid, write_reg_11_index, conflict_cnt} !== '0 ||
            write_reg_11_xor !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs arb %h valid %h cnt %h want all zero",
                     arbiter_result, write_reg_11_valid, conflict_cnt);
        end
        reset = 1'b0;
        clear_req();
    endtask

    task automatic test_single();
        logic [NR-1:0] r;
        set_req(0, 2, 12'h0A5, 64'h1234);
        #1;
        vec_cnt++;
        if (req_ready !== 32'h0000_0004) begin
            err_cnt++;
            $display("FAIL single_ready got %h want 00000004", req_ready);
        end
        drive_cycle(r);
        clear_req();
        vec_cnt++;
        if (arbiter_result[3:0] !== 4'b0100 || write_reg_11_valid !== 8'h01 ||
            write_reg_11_index[11:0] !== 12'h0A5 || write_reg_11_xor[2*DW +: DW] !== 64'h1234) begin
            err_cnt++;
            $display("FAIL single_out arb %b valid %h idx %h xor %h want 0100 01 0a5 1234",
                     arbiter_result[3:0], write_reg_11_valid, write_reg_11_index[11:0],
                     write_reg_11_xor[2*DW +: DW]);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] r;
        logic [3:0] want;
        for (int l = 0; l < NM; l++) set_req(3, l, 12'h100 + 12'(l), 64'(l));
        for (int k = 0; k < 5; k++) begin
            drive_cycle(r);
            want = 4'b0001 << (k % NM);
            vec_cnt++;
            if (arbiter_result[15:12] !== want || write_reg_11_valid[3] !== 1'b1) begin
                err_cnt++;
                $display("FAIL rr_step%0d arb %b valid3 %b want %b 1", k,
                         arbiter_result[15:12], write_reg_11_valid[3], want);
            end
        end
        clear_req();
    endtask

    task automatic test_conflict();
        logic [NR-1:0] r;
        logic [7:0]  want_v [2];
        logic [NR-1:0] want_r [2];
        want_v[0] = 8'h02; want_v[1] = 8'h20;
        want_r[0] = 32'h0000_0010; want_r[1] = 32'h0010_0000;
        do_reset();
        set_req(1, 0, 12'h3FF, 64'h11);
        set_req(5, 0, 12'h3FF, 64'h55);
        for (int k = 0; k < 2; k++) begin
            #1;
            vec_cnt++;
            if (req_ready !== want_r[k]) begin
                err_cnt++;
                $display("FAIL conflict_ready%0d got %h want %h", k, req_ready, want_r[k]);
            end
            drive_cycle(r);
            req_valid = req_valid & ~r;
            vec_cnt++;
            if (write_reg_11_valid !== want_v[k] || conflict_cnt !== 16'd1) begin
                err_cnt++;
                $display("FAIL conflict_out%0d valid %h cnt %0d want %h 1", k,
                         write_reg_11_valid, conflict_cnt, want_v[k]);
            end
        end
        clear_req();
    endtask

    task automatic test_triple();
        logic [NR-1:0] r;
        logic [7:0]  want_v [3];
        logic [15:0] want_c [3];
        want_v[0] = 8'h01; want_v[1] = 8'h04; want_v[2] = 8'h80;
        want_c[0] = 16'd2; want_c[1] = 16'd3; want_c[2] = 16'd3;
        do_reset();
        set_req(0, 0, 12'h010, 64'h1);
        set_req(2, 0, 12'h010, 64'h2);
        set_req(7, 0, 12'h010, 64'h7);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(r);
            req_valid = req_valid & ~r;
            vec_cnt++;
            if (write_reg_11_valid !== want_v[k] || conflict_cnt !== want_c[k]) begin
                err_cnt++;
                $display("FAIL triple_step%0d valid %h cnt %0d want %h %0d", k,
                         write_reg_11_valid, conflict_cnt, want_v[k], want_c[k]);
            end
        end
        clear_req();
    endtask

    task automatic test_pause();
        logic [NR-1:0] r;
        int pp [NW];
        for (int s = 0; s < NW; s++)
            for (int l = 0; l < NM; l++) set_req(s, l, 12'(s*NM + l), 64'(s*16 + l));
        drive_cycle(r);
        for (int s = 0; s < NW; s++) pp[s] = m_ptr[s];
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vec_cnt++;
            if (req_ready !== '0) begin
                err_cnt++;
                $display("FAIL pause_ready%0d got %h want 0", k, req_ready);
            end
            drive_cycle(r);
            vec_cnt++;
            if (write_reg_11_valid !== '0 || arbiter_result !== '0) begin
                err_cnt++;
                $display("FAIL pause_out%0d valid %h arb %h want 0 0", k,
                         write_reg_11_valid, arbiter_result);
            end
        end
        pause = 1'b0;
        drive_cycle(r);
        for (int s = 0; s < NW; s++) begin
            vec_cnt++;
            if (arbiter_result[s*NM +: NM] !== (4'b0001 << pp[s])) begin
                err_cnt++;
                $display("FAIL pause_resume_slot%0d arb %b want lane %0d", s,
                         arbiter_result[s*NM +: NM], pp[s]);
            end
        end
        clear_req();
    endtask

    task automatic test_saturation_reset();
        logic [NR-1:0] r;
        do_reset();
        for (int s = 0; s < NW; s++) set_req(s, 0, 12'h055, 64'(s));
        for (int k = 0; k < 10000; k++) drive_cycle(r);
        vec_cnt++;
        if (conflict_cnt !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL saturate got %h want ffff", conflict_cnt);
        end
        for (int l = 1; l < NM; l++) set_req(0, l, 12'h200 + 12'(l), 64'(l));
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== '0) begin
            err_cnt++;
            $display("FAIL reset_ready got %h want 0", req_ready);
        end
        drive_cycle(r);
        reset = 1'b0;
        vec_cnt++;
        if ({arbiter_result, write_reg_11_valid, write_reg_11_index, conflict_cnt} !== '0 ||
            write_reg_11_xor !== '0) begin
            err_cnt++;
            $display("FAIL midreset_out arb %h valid %h cnt %h want all zero",
                     arbiter_result, write_reg_11_valid, conflict_cnt);
        end
        #1;
        vec_cnt++;
        if (req_ready[3:0] !== 4'b0001) begin
            err_cnt++;
            $display("FAIL reset_ptr slot0 ready %b want 0001", req_ready[3:0]);
        end
        drive_cycle(r);
        clear_req();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NW; i++) m_ptr[i] = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_conflict();
        test_triple();
        test_pause();
        test_saturation_reset();
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uram_update_write_arbiter.md
Name: uram_update_write_arbiter

Overview:
- Front-end scheduler for the hash-table row write path.
- Each of the NUM_WR write slots has NUM_MUL requesters (one per multiplier/hash lane). Per cycle, each slot grants one requester round-robin.
- Produces the per-slot one-hot lane select, valid, index and XOR vector that feed the row's write_reg_11_* inputs, all registered.
- Suppresses same-cycle grants that target an identical index in different slots, so no two slots write one address in one cycle.

Parameters:
- NUM_MUL, 4, requesters (hash lanes) per write slot.
- NUM_WR, 8, number of write slots.
- INDEX_WIDTH, 12, table index width.
- DATA_WIDTH, 64, per-lane XOR update width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pause  in  1  when high, no grants this cycle.
- req_valid  in  NUM_WR*NUM_MUL  request valid; bit i*NUM_MUL+m is slot i, lane m.
- req_ready  out  NUM_WR*NUM_MUL  combinational grant/accept, same bit mapping.
- req_index  in  NUM_WR*NUM_MUL*INDEX_WIDTH  per-requester index.
- req_xor  in  NUM_MUL*NUM_WR*DATA_WIDTH  per-requester XOR data; slot i occupies [NUM_MUL*DATA_WIDTH*i +: NUM_MUL*DATA_WIDTH].
- arbiter_result  out  NUM_WR*NUM_MUL  registered one-hot lane select per slot.
- write_reg_11_valid  out  NUM_WR  registered slot-write valid.
- write_reg_11_index  out  NUM_WR*INDEX_WIDTH  registered granted index per slot.
- write_reg_11_xor  out  NUM_MUL*NUM_WR*DATA_WIDTH  registered XOR vector.
- conflict_cnt  out  16  saturating count of suppressed grants.

Behaviour:
- Handshake: a transfer occurs when req_valid & req_ready. A requester holds valid, index and xor stable until accepted. req_ready is never asserted without req_valid.
- Candidate selection, per slot i:
  - Round-robin pointer ptr[i] (log2 NUM_MUL bits, reset 0).
  - Candidate = first valid lane scanning ptr[i], ptr[i]+1, ... modulo NUM_MUL.
  - No valid lane means no candidate.
- Index-conflict filter, evaluated in slot order 0..NUM_WR-1:
  - Slot i's candidate is suppressed if any slot j<i holds a surviving grant with an equal index.
  - Comparison is against surviving grants only.
  - Lowest slot always wins.
- Grant: surviving candidates assert req_ready, unless pause=1, in which case all req_ready=0.
- Pointer update: ptr[i] <= granted lane+1, wrapping NUM_MUL-1 to 0. ptr[i] is unchanged on no grant, suppression or pause.
- Outputs, registered with 1-cycle latency from the accept cycle:
  - arbiter_result[i*NUM_MUL+m] = 1 iff lane m granted.
  - write_reg_11_valid[i] = 1 iff any lane in slot i is granted.
  - write_reg_11_index slot i = granted lane's index, 0 if no grant.
  - write_reg_11_xor = req_xor captured that cycle.
  - A slot with no grant outputs valid 0 and arbiter_result 0 next cycle. There is no hold behaviour.
- pause: cycle after pause=1, all write_reg_11_valid=0 and arbiter_result=0. Pointers are frozen.
- conflict_cnt:
  - Increments by the number of slots suppressed this cycle (0..NUM_WR-1).
  - Saturates at 16'hFFFF.
  - Not incremented while pause=1.
- Reset:
  - arbiter_result, write_reg_11_valid, write_reg_11_index, write_reg_11_xor, conflict_cnt all 0.
  - All ptr = 0; req_ready = 0 during the reset cycle.
  - Reset mid-stream discards any in-flight registered grant; requesters re-present after reset.
- Simultaneous events: reset overrides pause, which overrides grant. Conflict and round-robin are evaluated in the same cycle.

Test Plan:
1. Single request: after reset, slot 0 lane 2 valid, index 0x0A5, xor lane 2 = 64'h1234 -> req_ready bit 2 same cycle. Next cycle: arbiter_result[3:0]=4'b0100, write_reg_11_valid=8'h01, index slot0=0x0A5, xor lane 2=64'h1234.
2. Round-robin: slot 3, all 4 lanes valid continuously, distinct indices -> grants lane 0,1,2,3,0 on successive cycles; valid[3] high every cycle.
3. Index conflict: slots 1 and 5, each lane 0 valid, both index 0x3FF -> slot1 granted, slot5 ready=0, conflict_cnt=1. Next cycle slot5 granted, cnt stays 1.
4. Triple conflict: slots 0, 2, 7, same index 0x010 -> only slot0 granted, conflict_cnt +2. Repeat until all drained; total increments 2+1=3.
5. Pause: all 32 requesters valid, pause=1 for 3 cycles -> req_ready=0 and write_reg_11_valid=0 throughout, pointers unchanged. First grant after pause is lane ptr as before the pause.
6. Saturation/reset: force 70000 suppressions -> conflict_cnt=16'hFFFF. Assert reset with grants pending -> next cycle all outputs 0, ptrs 0.
